// File: rtl/dds2note_pitch.sv
// dds2note_pitch: converts a 32-bit DDS phase increment back to the nearest
// lower MIDI note and an FRAC_W-bit fraction of a semitone. It reads the
// note2dds table one entry at a time: a range check, a binary search, an
// endpoint fetch, then a restoring divide for the fraction.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous reset, active low
//   start     conversion request, sampled only while busy=0
//   adder_in  phase increment, captured on the edge that accepts start
//   busy      conversion in progress
//   done      one-cycle pulse when the results update
//   note_out  integer note n, with T[n] <= adder < T[n+1]
//   frac_out  floor(2^FRAC_W * (adder - T[n]) / (T[n+1] - T[n]))
//   below     adder_in < T[0]
//   above     adder_in >= T[NOTE_MAX]

// note2dds: registered note-to-phase-increment table.
// The 12 entries of one octave are scaled by 2^octave. Entry 0 is 2^21, so
// note 127 still fits in 32 bits. Notes above 127 saturate to all ones.
//   clk   clock
//   note  9-bit note index
//   dds   phase increment, registered (valid one edge after note)
module note2dds (
    input  logic        clk,
    input  logic [8:0]  note,
    output logic [31:0] dds
);
    logic [6:0]  oct;
    logic [3:0]  semi;
    logic [31:0] base;

    always_comb begin
        oct  = note[6:0] / 7'd12;
        semi = 4'(note[6:0] % 7'd12);
        case (semi)
            4'd0:    base = 32'd2097152;
            4'd1:    base = 32'd2221855;
            4'd2:    base = 32'd2353973;
            4'd3:    base = 32'd2493949;
            4'd4:    base = 32'd2642246;
            4'd5:    base = 32'd2799362;
            4'd6:    base = 32'd2965822;
            4'd7:    base = 32'd3142178;
            4'd8:    base = 32'd3329021;
            4'd9:    base = 32'd3526980;
            4'd10:   base = 32'd3736703;
            4'd11:   base = 32'd3958898;
            default: base = 32'd2097152;
        endcase
    end

    always_ff @(posedge clk) begin
        if (note[8:7] != 2'b00) dds <= '1;
        else                    dds <= base << oct;
    end
endmodule

module dds2note_pitch #(
    parameter int NOTE_MAX = 127,
    parameter int FRAC_W   = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [31:0]                    adder_in,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(NOTE_MAX+1)-1:0]  note_out,
    output logic [FRAC_W-1:0]              frac_out,
    output logic                           below,
    output logic                           above
);
    localparam int IDX_W = $clog2(NOTE_MAX + 1);
    localparam int ITERS = $clog2(NOTE_MAX);   // search span is 0..NOTE_MAX-1
    localparam int IT_W  = $clog2(ITERS);
    localparam int CNT_W = $clog2(FRAC_W);

    localparam logic [3:0] S_IDLE = 4'd0,
                           S_SET0 = 4'd1,
                           S_CMP0 = 4'd2,
                           S_SETH = 4'd3,
                           S_CMPH = 4'd4,
                           S_SETM = 4'd5,
                           S_CMPM = 4'd6,
                           S_SETL = 4'd7,
                           S_CMPL = 4'd8,
                           S_SETU = 4'd9,
                           S_CMPU = 4'd10,
                           S_DIV  = 4'd11,
                           S_FIN  = 4'd12;

    logic [3:0]        state;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       q;
    logic [31:0]       tgt;
    logic [IDX_W-1:0]  lo, hi, lo_n, hi_n, nxt_mid;
    logic [IDX_W:0]    sum;
    logic [IT_W-1:0]   it;
    logic [31:0]       lower, den, rem;
    logic [32:0]       r2;
    logic              ge;
    logic [FRAC_W-1:0] quot;
    logic [CNT_W-1:0]  cnt;
    logic              r_below, r_above;

    note2dds u_tbl (
        .clk  (clk),
        .note (9'(idx)),
        .dds  (q)
    );

    assign busy = (state != S_IDLE);

    // Search step: idx holds mid while in CMPM; the next mid is formed from
    // the updated bounds so it can be registered on the same edge.
    always_comb begin
        lo_n = lo;
        hi_n = hi;
        if (q <= tgt) lo_n = idx;
        else          hi_n = idx - IDX_W'(1);
        sum     = {1'b0, lo_n} + {1'b0, hi_n} + (IDX_W+1)'(1);
        nxt_mid = sum[IDX_W:1];
    end

    // Restoring divide step. rem < den always holds, so the shifted
    // remainder needs only one extra bit.
    always_comb begin
        r2 = {rem, 1'b0};
        ge = (r2 >= {1'b0, den});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            tgt      <= '0;
            lo       <= '0;
            hi       <= '0;
            it       <= '0;
            lower    <= '0;
            den      <= '0;
            rem      <= '0;
            quot     <= '0;
            cnt      <= '0;
            r_below  <= 1'b0;
            r_above  <= 1'b0;
            done     <= 1'b0;
            note_out <= '0;
            frac_out <= '0;
            below    <= 1'b0;
            above    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    tgt     <= adder_in;
                    idx     <= '0;
                    lo      <= '0;
                    hi      <= IDX_W'(NOTE_MAX - 1);
                    it      <= '0;
                    r_below <= 1'b0;
                    r_above <= 1'b0;
                    state   <= S_SET0;
                end
                S_SET0: state <= S_CMP0;
                S_CMP0: begin
                    if (tgt < q) begin
                        r_below <= 1'b1;
                        state   <= S_FIN;
                    end else begin
                        idx   <= IDX_W'(NOTE_MAX);
                        state <= S_SETH;
                    end
                end
                S_SETH: state <= S_CMPH;
                S_CMPH: begin
                    if (tgt >= q) begin
                        r_above <= 1'b1;
                        state   <= S_FIN;
                    end else begin
                        idx   <= IDX_W'(NOTE_MAX / 2);  // (0 + NOTE_MAX-1 + 1) >> 1
                        state <= S_SETM;
                    end
                end
                S_SETM: state <= S_CMPM;
                S_CMPM: begin
                    lo <= lo_n;
                    hi <= hi_n;
                    if (it == IT_W'(ITERS - 1)) begin
                        idx   <= lo_n;
                        state <= S_SETL;
                    end else begin
                        it    <= it + IT_W'(1);
                        idx   <= nxt_mid;
                        state <= S_SETM;
                    end
                end
                S_SETL: state <= S_CMPL;
                S_CMPL: begin
                    lower <= q;
                    idx   <= lo + IDX_W'(1);
                    state <= S_SETU;
                end
                S_SETU: state <= S_CMPU;
                S_CMPU: begin
                    den   <= q - lower;
                    rem   <= tgt - lower;
                    quot  <= '0;
                    cnt   <= '0;
                    state <= S_DIV;
                end
                S_DIV: begin
                    rem  <= ge ? 32'(r2 - {1'b0, den}) : r2[31:0];
                    quot <= {quot[FRAC_W-2:0], ge};
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(FRAC_W - 1)) state <= S_FIN;
                end
                S_FIN: begin
                    done     <= 1'b1;
                    below    <= r_below;
                    above    <= r_above;
                    note_out <= r_above ? IDX_W'(NOTE_MAX) : lo;
                    // A flat table segment (den=0) yields all-ones quotient
                    // bits; report a zero fraction instead.
                    frac_out <= (r_below || r_above || den == 32'd0) ? '0 : quot;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dds2note_pitch.sv
module tb_dds2note_pitch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] adder_in;
    logic        busy, done, below, above;
    logic [6:0]  note_out;
    logic [7:0]  frac_out;

    int n_assert = 0;
    int n_fail   = 0;

    dds2note_pitch #(.NOTE_MAX(127), .FRAC_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .adder_in (adder_in),
        .busy     (busy),
        .done     (done),
        .note_out (note_out),
        .frac_out (frac_out),
        .below    (below),
        .above    (above)
    );

    always #5 clk = ~clk;

    // Reference table: one octave of equal-tempered steps from 2^21, doubled
    // per octave.
    function automatic logic [31:0] tval(input int k);
        logic [31:0] b;
        case (k % 12)
            0:  b = 32'd2097152;
            1:  b = 32'd2221855;
            2:  b = 32'd2353973;
            3:  b = 32'd2493949;
            4:  b = 32'd2642246;
            5:  b = 32'd2799362;
            6:  b = 32'd2965822;
            7:  b = 32'd3142178;
            8:  b = 32'd3329021;
            9:  b = 32'd3526980;
            10: b = 32'd3736703;
            default: b = 32'd3958898;
        endcase
        return b << (k / 12);
    endfunction

    function automatic int mnote(input logic [31:0] x);
        int n = 0;
        for (int k = 0; k <= 126; k++) if (tval(k) <= x) n = k;
        return n;
    endfunction

    function automatic int mfrac(input logic [31:0] x, input int n);
        longint num, den;
        num = longint'(x) - longint'(tval(n));
        den = longint'(tval(n + 1)) - longint'(tval(n));
        return int'((num * 256) / den);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Entered #1 after an edge; returns #1 after edge 0.
    task automatic start_conv(input logic [31:0] x);
        start    = 1'b1;
        adder_in = x;
        @(posedge clk); #1;
        start    = 1'b0;
        adder_in = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic conv(input string tag, input logic [31:0] x, input int en, input int ef,
                        input bit eb, input bit ea, input int elat);
        int lat;
        start_conv(x);
        check({tag, "_busy_hi"}, 32'(busy), 32'd1);
        wait_done(lat);
        check({tag, "_lat"},    32'(lat),      32'(elat));
        check({tag, "_note"},   32'(note_out), 32'(en));
        check({tag, "_frac"},   32'(frac_out), 32'(ef));
        check({tag, "_below"},  32'(below),    32'(eb));
        check({tag, "_above"},  32'(above),    32'(ea));
        check({tag, "_busy_lo"}, 32'(busy),    32'd0);
    endtask

    initial begin
        int lat, seen, n;
        logic [31:0] x;
        rst_n    = 1'b0;
        start    = 1'b0;
        adder_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_note", 32'(note_out), 32'd0);
        check("rst_frac", 32'(frac_out), 32'd0);
        check("rst_flags", {30'd0, below, above}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        conv("t60", tval(60), 60, 0, 0, 0, 31);
        // results hold after done
        repeat (2) @(posedge clk);
        #1;
        check("hold_done", 32'(done), 32'd0);
        check("hold_note", 32'(note_out), 32'd60);

        // T[69] = 112863360, T[70] = 119574496, half step = 3355568
        conv("half69", 32'd112863360 + 32'd3355568, 69, 128, 0, 0, 31);
        conv("zero", 32'd0, 0, 0, 1, 0, 3);
        conv("ffff", 32'hFFFFFFFF, 127, 0, 0, 1, 5);
        conv("t127", tval(127), 127, 0, 0, 1, 5);
        conv("t127m1", tval(127) - 32'd1, 126, 255, 0, 0, 31);

        // reset at edge 12 of a conversion
        start_conv(tval(50));
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_note", 32'(note_out), 32'd0);
        check("midrst_frac", 32'(frac_out), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("midrst_nodone", 32'(seen), 32'd0);
        conv("t100", tval(100), 100, 0, 0, 0, 31);

        conv("t0", tval(0), 0, 0, 0, 0, 31);

        // start during busy is ignored
        start_conv(tval(40));
        repeat (9) @(posedge clk);
        #1;
        start    = 1'b1;
        adder_in = tval(90);
        @(posedge clk); #1;
        start    = 1'b0;
        wait_done(lat);
        check("ign_lat", 32'(lat + 10), 32'd31);
        check("ign_note", 32'(note_out), 32'd40);
        check("ign_frac", 32'(frac_out), 32'd0);
        @(posedge clk); #1;
        check("ign_noqueue", 32'(busy), 32'd0);

        // random in-range sweep against the reference model
        for (int i = 0; i < 1000; i++) begin
            x = $urandom_range(tval(127) - 32'd1, tval(0));
            n = mnote(x);
            start_conv(x);
            wait_done(lat);
            check("sw_lat",  32'(lat), 32'd31);
            check("sw_note", 32'(note_out), 32'(n));
            check("sw_frac", 32'(frac_out), 32'(mfrac(x, n)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/dds2note_pitch.md
# dds2note_pitch

Inverse of the note/pitch-to-DDS path: takes a 32-bit DDS phase increment (`adder` word) and recovers the nearest lower MIDI note plus an 8-bit fractional semitone. It shares the `note2dds` lookup table with the synthesis path and reads it sequentially. It sits beside the oscillator bank for tuner display, glide-target tracking and self-test of the pitch path. Each conversion is start/done handshaked and finishes in a fixed number of cycles per outcome class.

## Interface

- `NOTE_MAX`, 127: highest table index searched.
- `FRAC_W`, 8: fractional bits produced; 1 semitone = 2^FRAC_W.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous reset, active low.
- `start`  in  1  request a conversion; sampled only while `busy`=0.
- `adder_in`  in  32  phase increment to convert; captured on the edge that accepts `start`.
- `busy`  out  1  conversion in progress.
- `done`  out  1  one-cycle pulse; result outputs are valid from this cycle until the next `done`.
- `note_out`  out  7  integer note n.
- `frac_out`  out  8  fraction within [n, n+1).
- `below`  out  1  `adder_in` < T[0].
- `above`  out  1  `adder_in` ≥ T[NOTE_MAX].

## Operation

- T[k] is the output of an internal `note2dds` instance with 9-bit note input = {2'b0, idx}. The table registers its output, so the data is valid one edge after `idx` is registered. Each lookup costs one SET cycle plus one CMP cycle.
- States and transitions:
  - IDLE: on `start`, latch `tgt`=`adder_in` and go to SET0.
  - SET0 → CMP0. In CMP0, if `tgt` < T[0], go to FINISH with `below`=1, n=0, frac=0.
  - SET127 → CMP127. In CMP127, if `tgt` ≥ T[127], go to FINISH with `above`=1, n=127, frac=0.
  - Binary search over lo=0, hi=126, exactly 7 iterations (SETM/CMPM):
    - mid = (lo+hi+1)>>1.
    - If T[mid] ≤ `tgt`, then lo=mid; else hi=mid−1.
    - Result: n=lo, with T[n] ≤ `tgt` < T[n+1].
  - SETL → CMPL: latch `lower`=T[n].
  - SETU → CMPU: latch `upper`=T[n+1].
  - DIV, 8 cycles of restoring division:
    - num = `tgt`−`lower`, den = `upper`−`lower`, using a 33-bit remainder.
    - Per cycle: r = r<<1; if r ≥ den then r −= den and the result bit is 1. Bits are produced MSB first.
    - Result: frac = floor(256·num/den), always ≤ 255 because num < den.
    - If den = 0 (non-monotonic table), frac = 0.
  - FINISH: register all outputs and pulse `done`, then return to IDLE.
- All comparisons are unsigned 32-bit.
- `adder_in` changes after capture have no effect.
- `start` while `busy`=1 is ignored and not queued.
- `below` and `above` are both 0 for an in-range result and are never both 1.

## Timing

- Edge 0 is the edge that accepts `start`. `done` is high in the cycle after edge N:
  - N=3 for `below`.
  - N=5 for `above`.
  - N=31 in range (4 range-check + 14 search + 4 endpoint fetch + 8 divide + 1 finish).
- `busy` rises after edge 0 and falls after edge N, coinciding with `done`. A new `start` is accepted in the `done` cycle.
- Result outputs update only at the `done` edge and hold otherwise.
- Reset (`rst_n`=0 at any edge, including mid-conversion):
  - State returns to IDLE.
  - `busy`, `done`, `below`, `above`=0; `note_out`, `frac_out`=0.
  - No `done` is issued for the aborted conversion.
  - The first `start` after release behaves normally.

## Test plan

- `adder_in`=T[60] → `done` at N=31, `note_out`=60, `frac_out`=0, `below`=`above`=0.
- `adder_in`=T[69]+(T[70]−T[69])/2, with the difference even → `note_out`=69, `frac_out`=128. Sweep 1000 random in-range values against the bench model floor(256·(x−T[n])/(T[n+1]−T[n])).
- `adder_in`=0 → N=3, `below`=1, `note_out`=0, `frac_out`=0. `adder_in`=32'hFFFFFFFF → N=5, `above`=1, `note_out`=127, `frac_out`=0.
- Boundaries:
  - `adder_in`=T[127]−1 → `note_out`=126, `frac_out`=255 or the model value.
  - `adder_in`=T[0] → `note_out`=0, `frac_out`=0, `below`=0.
- Start `adder_in`=T[40], pulse `start` again at edge 10 with T[90] → ignored; result `note_out`=40 at N=31.
- Drive `rst_n`=0 at edge 12 of a conversion → outputs 0, no `done`. Then `start` with T[100] → `note_out`=100 after 31 edges.
